cdc_src_clear_fifo: RTL and testbench

- Source-domain front end that sits directly upstream of the clearable two-phase CDC and feeds its src-side interface.
- Buffers up to DEPTH items and presents them to the CDC.
- Sequences a local flush request into a legal CDC clear: valid is low while the clear is issued, and no clear is issued while a clear is already pending.
- Optionally discards buffered data when the destination side starts a clear.

---
 rtl/cdc_src_clear_fifo.sv | 171 +++++++++++++++++
 tb/tb_cdc_src_clear_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_src_clear_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdc_src_clear_fifo
// Brief    : Source-domain buffer in front of a clearable two-phase CDC.
//            Holds up to DEPTH items, turns a level flush request into a
//            single legal clear pulse towards the CDC, and optionally drops
//            buffered data when the far side starts a clear.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_src_clear_fifo #(
    parameter type         T                     = logic,
    parameter int unsigned DEPTH                 = 4,
    parameter bit          FLUSH_ON_REMOTE_CLEAR = 1'b1
) (
    input  logic                       src_clk_i,
    input  logic                       src_rst_ni,
    input  logic                       flush_i,
    output logic                       flush_busy_o,
    input  T                           in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output T                           cdc_data_o,
    output logic                       cdc_valid_o,
    input  logic                       cdc_ready_i,
    output logic                       cdc_clear_o,
    input  logic                       cdc_clear_pending_i,
    output logic [$clog2(DEPTH+1)-1:0] fill_o
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HOLD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_run;
    logic                 w_issue;

    T                     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_remote_flush;
    logic                 w_clear_fifo;

    // State register for the flush/clear sequencer.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded controls of the sequencer.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_run = 1'b1;
                if (flush_i) begin
                    // A clear may only be issued once the CDC is idle.
                    w_state_next = cdc_clear_pending_i ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (!cdc_clear_pending_i) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (cdc_clear_pending_i) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!cdc_clear_pending_i) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Valid and ready are gated combinationally by pending so that no
    // handshake can slip through in the cycle a clear starts.
    assign in_ready_o  = w_run & ~cdc_clear_pending_i & ~w_full;
    assign cdc_valid_o = w_run & ~cdc_clear_pending_i & ~w_empty;
    assign cdc_data_o  = r_mem[r_rd_ptr];
    assign cdc_clear_o = w_issue;
    assign flush_busy_o = ~w_run | cdc_clear_pending_i;
    assign fill_o      = r_count;

    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = cdc_valid_o & cdc_ready_i;

    // Remote clear: pending seen while running; our own clears are pending
    // only outside RUN, so they never match this term.
    assign w_remote_flush = FLUSH_ON_REMOTE_CLEAR & w_run & cdc_clear_pending_i;
    assign w_clear_fifo   = w_issue | w_remote_flush;

    // Payload storage; contents need no reset since count guards them.
    always_ff @(posedge src_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear_fifo) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_clear_no_valid : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        cdc_clear_o |-> !cdc_valid_o);
    a_clear_not_pending : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        cdc_clear_o |-> !cdc_clear_pending_i);
    a_no_overflow : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        w_push |-> !w_full);
    a_no_underflow : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        w_pop |-> !w_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdc_src_clear_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_src_clear_fifo
// Brief    : Self-checking bench for cdc_src_clear_fifo. Two instances share
//            all inputs: one discards data on remote clear, one retains it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_src_clear_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       cdc_ready;
    logic       pending;

    // index 1: discards on remote clear, index 0: retains
    logic       busy   [2];
    logic       irdy   [2];
    logic [7:0] cdata  [2];
    logic       cvalid [2];
    logic       clr    [2];
    logic [2:0] fill   [2];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cdc_src_clear_fifo #(.T(logic [7:0]), .DEPTH(4), .FLUSH_ON_REMOTE_CLEAR(1'b1)) u_dut1 (
        .src_clk_i(clk), .src_rst_ni(rst_n), .flush_i(flush), .flush_busy_o(busy[1]),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(irdy[1]),
        .cdc_data_o(cdata[1]), .cdc_valid_o(cvalid[1]), .cdc_ready_i(cdc_ready),
        .cdc_clear_o(clr[1]), .cdc_clear_pending_i(pending), .fill_o(fill[1]));

    cdc_src_clear_fifo #(.T(logic [7:0]), .DEPTH(4), .FLUSH_ON_REMOTE_CLEAR(1'b0)) u_dut0 (
        .src_clk_i(clk), .src_rst_ni(rst_n), .flush_i(flush), .flush_busy_o(busy[0]),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(irdy[0]),
        .cdc_data_o(cdata[0]), .cdc_valid_o(cvalid[0]), .cdc_ready_i(cdc_ready),
        .cdc_clear_o(clr[0]), .cdc_clear_pending_i(pending), .fill_o(fill[0]));

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        int         exp_fill;
        logic       exp_irdy;
        logic       exp_vld;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] mq [2][$];
    logic [7:0] got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cdc_ready = 1'b0;
        pending   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_items(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int clr_cnt;
        int pend_left;
        int in_idx;
        logic exp_ir;
        logic exp_v;

        tbl[0] = '{1'b1, 8'h0A, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h0B, 1'b0, 1, 1'b1, 1'b1, 8'h0A};
        tbl[2] = '{1'b1, 8'h0C, 1'b0, 2, 1'b1, 1'b1, 8'h0A};
        tbl[3] = '{1'b1, 8'h0D, 1'b0, 3, 1'b1, 1'b1, 8'h0A};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b1, 8'h0A};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b1, 8'h0A};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h0B};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h0C};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h0D};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00};

        // ---------------- reset values ----------------
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_fill", 32'(fill[1]), 0);
        chk("rst_valid", 32'(cvalid[1]), 0);
        chk("rst_clear", 32'(clr[1]), 0);
        chk("rst_busy", 32'(busy[1]), 0);
        chk("rst_in_ready", 32'(irdy[1]), 1);
        do_reset();

        // ---------------- fill to full, then drain in order ----------------
        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            cdc_ready = tbl[i].rdy;
            #1;
            chk($sformatf("t1_fill[%0d]", i), 32'(fill[1]), 32'(tbl[i].exp_fill));
            chk($sformatf("t1_in_ready[%0d]", i), 32'(irdy[1]), 32'(tbl[i].exp_irdy));
            chk($sformatf("t1_valid[%0d]", i), 32'(cvalid[1]), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld)
                chk($sformatf("t1_data[%0d]", i), 32'(cdata[1]), 32'(tbl[i].exp_dat));
            tick();
        end
        idle_inputs();

        // ---------------- wrap-around streaming ----------------
        do_reset();
        got.delete();
        in_idx = 0;
        for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
            in_valid  = (in_idx < 10);
            in_data   = 8'h10 + 8'(in_idx);
            cdc_ready = cyc[0];
            #1;
            if (cvalid[1] && cdc_ready) got.push_back(cdata[1]);
            if (in_valid && irdy[1]) in_idx++;
            tick();
        end
        idle_inputs();
        chk("t2_count", 32'(got.size()), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            chk($sformatf("t2_order[%0d]", i), 32'(got[i]), 32'(8'h10 + 8'(i)));

        // ---------------- local flush with 3 items ----------------
        do_reset();
        push_items(3, 8'h30);
        #1;
        chk("t3_fill_before", 32'(fill[1]), 3);
        flush = 1'b1;
        #1;
        chk("t3_busy_run", 32'(busy[1]), 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t3_clear_pulse", 32'(clr[1]), 1);
        chk("t3_clear_valid", 32'(cvalid[1]), 0);
        chk("t3_busy_issue", 32'(busy[1]), 1);
        tick();
        #1;
        chk("t3_fill_after", 32'(fill[1]), 0);
        chk("t3_clear_single", 32'(clr[1]), 0);
        chk("t3_busy_ack", 32'(busy[1]), 1);
        pending = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_busy_pend[%0d]", i), 32'(busy[1]), 1);
            chk($sformatf("t3_ready_pend[%0d]", i), 32'(irdy[1]), 0);
            tick();
        end
        pending = 1'b0;
        #1;
        chk("t3_busy_done", 32'(busy[1]), 1);
        tick();
        #1;
        chk("t3_busy_run_again", 32'(busy[1]), 0);
        chk("t3_ready_run_again", 32'(irdy[1]), 1);

        // ---------------- flush while a clear is pending ----------------
        do_reset();
        pending = 1'b1;
        flush   = 1'b1;
        #1;
        chk("t4_busy", 32'(busy[1]), 1);
        chk("t4_clear_run", 32'(clr[1]), 0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_hold_clear[%0d]", i), 32'(clr[1]), 0);
            chk($sformatf("t4_hold_ready[%0d]", i), 32'(irdy[1]), 0);
            tick();
        end
        pending   = 1'b0;
        clr_cnt   = 0;
        pend_left = 0;
        for (int i = 0; i < 8; i++) begin
            if (pend_left > 0) begin
                pending = 1'b1;
                pend_left--;
            end else begin
                pending = 1'b0;
            end
            #1;
            if (clr[1]) begin
                clr_cnt++;
                pend_left = 2;
            end
            tick();
        end
        pending = 1'b0;
        chk("t4_clear_count", 32'(clr_cnt), 1);
        #1;
        chk("t4_busy_end", 32'(busy[1]), 0);

        // ---------------- remote clear with 2 items ----------------
        do_reset();
        push_items(2, 8'h55);
        #1;
        chk("t5_fill1_before", 32'(fill[1]), 2);
        chk("t5_fill0_before", 32'(fill[0]), 2);
        pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_valid1[%0d]", i), 32'(cvalid[1]), 0);
            chk($sformatf("t5_valid0[%0d]", i), 32'(cvalid[0]), 0);
            tick();
        end
        pending = 1'b0;
        #1;
        chk("t5_fill1_after", 32'(fill[1]), 0);
        chk("t5_fill0_after", 32'(fill[0]), 2);
        chk("t5_valid1_after", 32'(cvalid[1]), 0);
        chk("t5_valid0_after", 32'(cvalid[0]), 1);
        chk("t5_data0_first", 32'(cdata[0]), 32'h55);
        cdc_ready = 1'b1;
        tick();
        #1;
        chk("t5_data0_second", 32'(cdata[0]), 32'h56);
        tick();
        #1;
        chk("t5_fill0_drained", 32'(fill[0]), 0);
        chk("t5_valid0_drained", 32'(cvalid[0]), 0);
        cdc_ready = 1'b0;

        // ---------------- asynchronous reset ----------------
        do_reset();
        push_items(2, 8'h70);
        #1;
        chk("t6_fill_before", 32'(fill[1]), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_fill_async", 32'(fill[1]), 0);
        chk("t6_valid_async", 32'(cvalid[1]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        #1;
        chk("t6_busy_wait_ack", 32'(busy[1]), 1);
        chk("t6_ready_wait_ack", 32'(irdy[1]), 0);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_async", 32'(busy[1]), 0);
        chk("t6_ready_async", 32'(irdy[1]), 1);
        chk("t6_clear_async", 32'(clr[1]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("t6_busy_run", 32'(busy[1]), 0);
        chk("t6_fill_run", 32'(fill[1]), 0);
        chk("t6_ready_run", 32'(irdy[1]), 1);

        // ---------------- randomized traffic with remote clears ----------------
        do_reset();
        mq[0].delete();
        mq[1].delete();
        pend_left = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (pend_left > 0) begin
                pending = 1'b1;
                pend_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                pending   = 1'b1;
                pend_left = int'($urandom_range(0, 3));
            end else begin
                pending = 1'b0;
            end
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            cdc_ready = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_ir = !pending && (mq[k].size() < 4);
                exp_v  = !pending && (mq[k].size() > 0);
                chk($sformatf("rnd%0d_in_ready[%0d]", k, cyc), 32'(irdy[k]), 32'(exp_ir));
                chk($sformatf("rnd%0d_valid[%0d]", k, cyc), 32'(cvalid[k]), 32'(exp_v));
                chk($sformatf("rnd%0d_fill[%0d]", k, cyc), 32'(fill[k]), 32'(mq[k].size()));
                chk($sformatf("rnd%0d_busy[%0d]", k, cyc), 32'(busy[k]), 32'(pending));
                chk($sformatf("rnd%0d_clear[%0d]", k, cyc), 32'(clr[k]), 0);
                if (exp_v)
                    chk($sformatf("rnd%0d_data[%0d]", k, cyc), 32'(cdata[k]), 32'(mq[k][0]));
                if (pending) begin
                    if (k == 1) mq[k].delete();
                end else begin
                    if (exp_v && cdc_ready) void'(mq[k].pop_front());
                    if (in_valid && exp_ir) mq[k].push_back(in_data);
                end
            end
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
